// File: rtl/spi_regfile_periph.sv
// rtl/spi_regfile_periph.sv - SPI mode-0 peripheral exposing a committed-on-nCS-rise register bank.
// Optional cipo readback of the addressed register is built when SPI_READBACK_EN is defined.
module spi_regfile_periph #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam logic [CNT_W-1:0]  CNT_FRAME  = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0]  CNT_OVF    = CNT_W'(FRAME + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  logic [2:0]        sclk_s;
  logic [2:0]        ncs_s;
  logic [1:0]        copi_s;
  logic              sclk_rise;
  logic              ncs_rise_q;
  logic              ncs_fall_q;
  logic              active;
  logic [CNT_W-1:0]  bit_cnt;
  logic [FRAME-1:0]  shift;
  logic [DATA_W-1:0] bank [NUM_REGS];

  logic              f_rw;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic              addr_ok;

  // Synchronisers reset low so a frame already underway at reset release never shows a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s     <= '0;
      ncs_s      <= '0;
      copi_s     <= '0;
      ncs_rise_q <= 1'b0;
      ncs_fall_q <= 1'b0;
    end else begin
      sclk_s     <= {sclk_s[1:0], sclk};
      ncs_s      <= {ncs_s[1:0], ncs};
      copi_s     <= {copi_s[0], copi};
      ncs_rise_q <= ncs_s[1] & ~ncs_s[2];
      ncs_fall_q <= ~ncs_s[1] & ncs_s[2];
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];

  assign f_rw    = shift[FRAME-1];
  assign f_addr  = shift[DATA_W +: ADDR_W];
  assign f_data  = shift[DATA_W-1:0];
  assign addr_ok = {1'b0, f_addr} < NUM_REGS_L;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (ncs_fall_q) begin
      active  <= 1'b1;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (ncs_rise_q) begin
      active  <= 1'b0;
    end else if (active && !ncs_s[1] && sclk_rise) begin
      shift <= {shift[FRAME-2:0], copi_s[1]};
      if (bit_cnt != CNT_OVF) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Evaluation of the finished frame; an empty frame is dropped without a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) bank[k] <= '0;
      wr_addr   <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (ncs_rise_q && active && bit_cnt != '0) begin
        if (bit_cnt != CNT_FRAME || !addr_ok) begin
          frame_err <= 1'b1;
        end else if (f_rw) begin
          wr_strobe <= 1'b1;
          wr_addr   <= f_addr;
          for (int k = 0; k < NUM_REGS; k++)
            if (f_addr == ADDR_W'(k)) bank[k] <= f_data;
        end
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int k = 0; k < NUM_REGS; k++) regs[k*DATA_W +: DATA_W] = bank[k];
  end

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_ADDR_DONE = CNT_W'(1 + ADDR_W);

  logic              sclk_fall;
  logic [DATA_W-1:0] snap;
  logic [DATA_W-1:0] out_sr;
  logic              cipo_q;

  assign sclk_fall = ~sclk_s[1] & sclk_s[2];

  // Mid-frame the address sits in the low bits of the shift register; out-of-range reads give 0.
  always_comb begin
    snap = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (shift[ADDR_W-1:0] == ADDR_W'(k)) snap = bank[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sr <= '0;
      cipo_q <= 1'b0;
    end else if (!active || ncs_s[1]) begin
      out_sr <= '0;
      cipo_q <= 1'b0;
    end else if (sclk_fall) begin
      if (bit_cnt == CNT_ADDR_DONE && !shift[ADDR_W]) begin
        cipo_q <= snap[DATA_W-1];
        out_sr <= snap << 1;
      end else begin
        cipo_q <= out_sr[DATA_W-1];
        out_sr <= out_sr << 1;
      end
    end
  end

  assign cipo    = cipo_q;
  assign cipo_oe = active;
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// tb/tb_spi_regfile_periph.sv - randomized frames vs. a frame-level register model, two DUT geometries.
`timescale 1ns/1ps
module tb_spi_regfile_periph;

  localparam int AW  = 7;
  localparam int N0  = 5;
  localparam int DW0 = 8;
  localparam int N1  = 8;
  localparam int DW1 = 16;

  typedef struct {
    int bus;
    int pc;
    int kind;
    int addr;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_p [2];
  logic copi_p [2];
  logic ncs_p  [2];
  logic cipo_a [2];
  logic oe_a   [2];
  logic ws_a   [2];
  logic fe_a   [2];
  logic [AW-1:0] wa_a [2];
  logic [N0*DW0-1:0] regs0;
  logic [N1*DW1-1:0] regs1;

  ev_t evq[$];
  logic [15:0]   mreg   [2][8];
  logic [AW-1:0] mwaddr [2];
  int rise_pc [2];
  int ns [2];
  int ne [2];
  int pc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;

  spi_regfile_periph #(.NUM_REGS(N0), .ADDR_W(AW), .DATA_W(DW0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_p[0]), .copi(copi_p[0]), .ncs(ncs_p[0]),
    .cipo(cipo_a[0]), .cipo_oe(oe_a[0]), .regs(regs0), .wr_strobe(ws_a[0]),
    .wr_addr(wa_a[0]), .frame_err(fe_a[0])
  );

  spi_regfile_periph #(.NUM_REGS(N1), .ADDR_W(AW), .DATA_W(DW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_p[1]), .copi(copi_p[1]), .ncs(ncs_p[1]),
    .cipo(cipo_a[1]), .cipo_oe(oe_a[1]), .regs(regs1), .wr_strobe(ws_a[1]),
    .wr_addr(wa_a[1]), .frame_err(fe_a[1])
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, pc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 8; k++) mreg[b][k] = '0;
      mwaddr[b] = '0;
    end
    evq.delete();
  endtask

  // Per-cycle compare: a frame's outcome lands exactly four cycles after its nCS rise.
  initial begin
    logic es [2];
    logic ee [2];
    logic [N0*DW0-1:0] f0;
    logic [N1*DW1-1:0] f1;
    ev_t ev;
    forever begin
      @(negedge clk);
      #1;
      es[0] = 1'b0; es[1] = 1'b0; ee[0] = 1'b0; ee[1] = 1'b0;
      while (evq.size() > 0 && evq[0].pc <= pc) begin
        ev = evq.pop_front();
        if (ev.kind == 1) begin
          mreg[ev.bus][ev.addr] = ev.data[15:0];
          mwaddr[ev.bus] = ev.addr[AW-1:0];
          es[ev.bus] = 1'b1;
        end else begin
          ee[ev.bus] = 1'b1;
        end
      end
      for (int k = 0; k < N0; k++) f0[k*DW0 +: DW0] = mreg[0][k][DW0-1:0];
      for (int k = 0; k < N1; k++) f1[k*DW1 +: DW1] = mreg[1][k];
      chk("regs0", 128'(regs0), 128'(f0));
      chk("regs1", 128'(regs1), 128'(f1));
      for (int b = 0; b < 2; b++) begin
        chk("wr_strobe", 128'(ws_a[b]), 128'(es[b]));
        chk("frame_err", 128'(fe_a[b]), 128'(ee[b]));
        chk("wr_addr", 128'(wa_a[b]), 128'(mwaddr[b]));
        if (ws_a[b]) ns[b] = ns[b] + 1;
        if (fe_a[b]) ne[b] = ne[b] + 1;
`ifdef SPI_READBACK_EN
        if (ncs_p[b] && pc >= rise_pc[b] + 4) begin
`else
        begin
`endif
          chk("cipo_idle", 128'(cipo_a[b]), 128'(1'b0));
          chk("cipo_oe_idle", 128'(oe_a[b]), 128'(1'b0));
        end
      end
    end
  end

  task automatic send_bits(input int bus, input int nbits, input logic [31:0] word, output logic [15:0] rb);
    rb = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi_p[bus] = word[i];
      repeat (4) @(negedge clk);
`ifdef SPI_READBACK_EN
      if (nbits - 1 - i >= 1 + AW) begin
        rb = {rb[14:0], cipo_a[bus]};
        chk("cipo_oe_frame", 128'(oe_a[bus]), 128'(1'b1));
      end
`endif
      sclk_p[bus] = 1'b1;
      repeat (4) @(negedge clk);
      sclk_p[bus] = 1'b0;
    end
  endtask

  task automatic frame_end(input int bus, input int nbits, input logic [31:0] word);
    int dw;
    int nregs;
    int rw;
    ev_t ev;
    repeat (4) @(negedge clk);
    ncs_p[bus] = 1'b1;
    rise_pc[bus] = pc;
    dw    = (bus == 1) ? DW1 : DW0;
    nregs = (bus == 1) ? N1 : N0;
    rw      = int'((word >> (dw + AW)) & 32'h1);
    ev.addr = int'((word >> dw) & 32'h7F);
    ev.data = int'(word & ((32'h1 << dw) - 32'h1));
    ev.bus  = bus;
    ev.pc   = pc + 4;
    ev.kind = 0;
    if (nbits == 0) ev.kind = 0;
    else if (nbits != 1 + AW + dw || ev.addr >= nregs) ev.kind = 2;
    else if (rw == 1) ev.kind = 1;
    if (ev.kind != 0) evq.push_back(ev);
    repeat (6) @(negedge clk);
  endtask

  task automatic send(input int bus, input int nbits, input logic [31:0] word, output logic [15:0] rb);
    @(negedge clk);
    ncs_p[bus] = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(bus, nbits, word, rb);
    frame_end(bus, nbits, word);
  endtask

  initial begin
    logic [15:0] rb;
    for (int b = 0; b < 2; b++) begin
      sclk_p[b] = 1'b0; copi_p[b] = 1'b0; ncs_p[b] = 1'b1;
      rise_pc[b] = 0; ns[b] = 0; ne[b] = 0;
    end
    model_clear();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    send(0, 16, 32'h82A5, rb);
    chk("lit_write_a5", 128'(regs0), 128'h0000A50000);
    chk("lit_waddr_2", 128'(wa_a[0]), 128'h02);
    chk("lit_strobes_1", 128'(ns[0]), 128'd1);

    send(0, 16, 32'h85FF, rb);
    chk("lit_badaddr_regs", 128'(regs0), 128'h0000A50000);
    chk("lit_badaddr_err", 128'(ne[0]), 128'd1);

    send(0, 15, 32'h40BB, rb);
    send(0, 17, 32'h102EE, rb);
    chk("lit_len_reg1", 128'(regs0[15:8]), 128'h00);
    chk("lit_len_errs", 128'(ne[0]), 128'd3);

    send(0, 16, 32'h843C, rb);
    send(0, 16, 32'h0400, rb);
`ifdef SPI_READBACK_EN
    chk("lit_readback_3c", 128'(rb[7:0]), 128'h3C);
`endif
    chk("lit_read_nostrobe", 128'(ns[0]), 128'd2);

    @(negedge clk);
    ncs_p[0] = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(0, 10, 32'h200, rb);
    rst_n = 1'b0;
    model_clear();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send_bits(0, 6, 32'h33, rb);
    repeat (4) @(negedge clk);
    ncs_p[0] = 1'b1;
    rise_pc[0] = pc;
    repeat (10) @(negedge clk);
    chk("lit_reset_regs", 128'(regs0), 128'h0);
    chk("lit_reset_nocommit", 128'(ns[0]), 128'd2);
    send(0, 16, 32'h8011, rb);
    chk("lit_after_reset_11", 128'(regs0), 128'h11);

    send(1, 24, 32'h87BEEF, rb);
    chk("lit_wide_beef", 128'(regs1[127:112]), 128'hBEEF);

    for (int t = 0; t < 60; t++) begin
      int bus;
      int dw;
      int nregs;
      int frame;
      int sel;
      int nbits;
      int addr;
      int rw;
      logic [31:0] w;
      logic [15:0] exp_rb;
      bus   = $urandom_range(0, 1);
      dw    = (bus == 1) ? DW1 : DW0;
      nregs = (bus == 1) ? N1 : N0;
      frame = 1 + AW + dw;
      sel   = $urandom_range(0, 9);
      if (sel < 6) nbits = frame;
      else if (sel == 6) nbits = frame - 1;
      else if (sel == 7) nbits = frame + 1;
      else if (sel == 8) nbits = 0;
      else nbits = $urandom_range(1, frame + 3);
      addr = $urandom_range(0, nregs + 1);
      rw   = $urandom_range(0, 1);
      w = (32'(rw) << (dw + AW)) | (32'(addr) << dw) | ($urandom & ((32'h1 << dw) - 32'h1));
      if (nbits != frame) w = $urandom;
      exp_rb = (addr < nregs) ? mreg[bus][addr] : 16'h0;
      send(bus, nbits, w, rb);
`ifdef SPI_READBACK_EN
      if (bus == 0 && rw == 0 && nbits == frame) chk("readback", 128'(rb[7:0]), 128'(exp_rb[7:0]));
`endif
    end

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
